opnd_conv_arb: RTL

OPND_CONV_ARB -- requirements
Module: opnd_conv_arb

---
 rtl/opnd_conv_arb_pkg.sv | 32 +++
 rtl/opnd_conv_arb_dec2bin.sv | 53 +++++
 rtl/opnd_conv_arb.sv | 136 +++++++++++++
 3 files changed

// File: rtl/opnd_conv_arb_pkg.sv
// Shared widths, FSM states and converter stage encodings for the operand converter/arbiter.
// Pure declarations; no timing or backpressure of its own.
package opnd_conv_arb_pkg;

    localparam int DIGIT_WIDTH  = 4;
    localparam int RESULT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LV1  = 3'd1,
        ST_LV2  = 3'd2,
        ST_LV3  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        STG_NONE = 2'b00,
        STG_LD1  = 2'b01,
        STG_MAG  = 2'b10,
        STG_SGN  = 2'b11
    } stage_e;

    function automatic stage_e stage_of(input state_e s);
        case (s)
            ST_LV1:  return STG_LD1;
            ST_LV2:  return STG_MAG;
            ST_LV3:  return STG_SGN;
            default: return STG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/opnd_conv_arb_dec2bin.sv
// Three-stage BCD-to-binary converter stepped by a stage code; one stage per cycle, no backpressure.
// Digits and sign must stay stable across all three stages.
module opnd_conv_arb_dec2bin
    import opnd_conv_arb_pkg::*;
#(
    parameter int DW = opnd_conv_arb_pkg::DIGIT_WIDTH,
    parameter int RW = opnd_conv_arb_pkg::RESULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  stage_e        stage_i,
    input  logic [DW-1:0] dig0_i,
    input  logic [DW-1:0] dig1_i,
    input  logic [DW-1:0] dig2_i,
    input  logic          sign_i,
    output logic [RW-1:0] mag_o,
    output logic [RW-1:0] signed_o,
    output logic          err_o
);

    logic [RW-1:0] hund_q;
    logic [RW-1:0] mag_q;
    logic [RW-1:0] sgn_q;
    logic          err_q;
    logic          bad_digit;

    assign bad_digit = (dig0_i > DW'(9)) || (dig1_i > DW'(9)) || (dig2_i > DW'(9));

    always_ff @(posedge clk) begin
        if (!rst) begin
            hund_q <= '0;
            mag_q  <= '0;
            sgn_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (stage_i)
                STG_LD1: hund_q <= RW'(dig2_i) * RW'(100);
                STG_MAG: begin
                    // An invalid digit zeroes the magnitude so the signed stage yields 0 too.
                    mag_q <= bad_digit ? '0 : hund_q + RW'(dig1_i) * RW'(10) + RW'(dig0_i);
                    err_q <= bad_digit;
                end
                STG_SGN: sgn_q <= sign_i ? (RW'(0) - mag_q) : mag_q;
                default: ;
            endcase
        end
    end

    assign mag_o    = mag_q;
    assign signed_o = sgn_q;
    assign err_o    = err_q;

endmodule

// File: rtl/opnd_conv_arb.sv
// Round-robin arbiter sharing one BCD converter between operands A and B; ack 4 cycles after grant edge.
// Requests are level-held and wait in place while busy; nothing is dropped.
module opnd_conv_arb
    import opnd_conv_arb_pkg::*;
#(
    parameter int DIGIT_WIDTH  = opnd_conv_arb_pkg::DIGIT_WIDTH,
    parameter int RESULT_WIDTH = opnd_conv_arb_pkg::RESULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_a,
    input  logic                    req_b,
    input  logic [DIGIT_WIDTH-1:0]  dig0_a,
    input  logic [DIGIT_WIDTH-1:0]  dig1_a,
    input  logic [DIGIT_WIDTH-1:0]  dig2_a,
    input  logic [DIGIT_WIDTH-1:0]  dig0_b,
    input  logic [DIGIT_WIDTH-1:0]  dig1_b,
    input  logic [DIGIT_WIDTH-1:0]  dig2_b,
    input  logic                    sign_a,
    input  logic                    sign_b,
    output logic                    ack_a,
    output logic                    ack_b,
    output logic [RESULT_WIDTH-1:0] result,
    output logic [RESULT_WIDTH-1:0] result_mag,
    output logic                    err,
    output logic                    busy
);

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic                    gnt_b_q, gnt_b_d;
    logic [DIGIT_WIDTH-1:0]  d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic                    sign_q, sign_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d, mag_q, mag_d;
    logic                    err_q, err_d;
    logic                    ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic                    pick_b;
    logic [RESULT_WIDTH-1:0] conv_mag, conv_signed;
    logic                    conv_err;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_b_d  = gnt_b_q;
        d0_d     = d0_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        sign_d   = sign_q;
        result_d = result_q;
        mag_d    = mag_q;
        err_d    = err_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        // ptr_q = 1 means B currently holds priority.
        pick_b   = req_b && (ptr_q || !req_a);
        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    gnt_b_d = pick_b;
                    ptr_d   = !pick_b;
                    d0_d    = pick_b ? dig0_b : dig0_a;
                    d1_d    = pick_b ? dig1_b : dig1_a;
                    d2_d    = pick_b ? dig2_b : dig2_a;
                    sign_d  = pick_b ? sign_b : sign_a;
                    state_d = ST_LV1;
                end
            end
            ST_LV1:  state_d = ST_LV2;
            ST_LV2:  state_d = ST_LV3;
            ST_LV3:  state_d = ST_DONE;
            ST_DONE: begin
                result_d = conv_signed;
                mag_d    = conv_mag;
                err_d    = conv_err;
                ack_a_d  = !gnt_b_q;
                ack_b_d  = gnt_b_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            gnt_b_q  <= 1'b0;
            d0_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            mag_q    <= '0;
            err_q    <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_b_q  <= gnt_b_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            mag_q    <= mag_d;
            err_q    <= err_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
        end
    end

    opnd_conv_arb_dec2bin #(
        .DW (DIGIT_WIDTH),
        .RW (RESULT_WIDTH)
    ) u_dec2bin (
        .clk      (clk),
        .rst      (rst),
        .stage_i  (stage_of(state_q)),
        .dig0_i   (d0_q),
        .dig1_i   (d1_q),
        .dig2_i   (d2_q),
        .sign_i   (sign_q),
        .mag_o    (conv_mag),
        .signed_o (conv_signed),
        .err_o    (conv_err)
    );

    assign ack_a      = ack_a_q;
    assign ack_b      = ack_b_q;
    assign result     = result_q;
    assign result_mag = mag_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
